// File: rtl/token_saver.sv
// token_saver: captures a token of up to MAX_DIGITS digit characters after a
// long/short trigger and writes it to a downstream FIFO. Each token is followed
// by SEP_CHAR. A token ends when it is full, on a non-digit (optional), or after
// an inactivity timeout. Digits that arrive while the FIFO is full are lost and
// reported on drop_err. The separator is held back until the FIFO has space.
// Optional feature macro: TOKEN_SAVER_TAG_EN. When it is defined, the block
// writes an "L"/"S" tag character before the digits.
module token_saver #(
    parameter int                DATA_W           = 8,
    parameter int                MAX_DIGITS       = 8,
    parameter logic [DATA_W-1:0] SEP_CHAR         = DATA_W'(8'h20),
    parameter bit                TERM_ON_NONDIGIT = 1'b1,
    parameter int                TIMEOUT          = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              is_number,
    input  logic              long,
    input  logic              short,
    input  logic              fifo_full,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              write,
    output logic              busy,
    output logic [7:0]        digit_cnt,
    output logic              drop_err
);

    // Reject parameter values that the counters cannot represent.
    if (MAX_DIGITS < 1 || MAX_DIGITS > 255) begin : g_bad_max_digits
        $error("token_saver: MAX_DIGITS must be in 1..255");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("token_saver: TIMEOUT must be in 2..65535");
    end

    localparam logic [7:0]  MAX_CNT    = 8'(MAX_DIGITS);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

`ifdef TOKEN_SAVER_TAG_EN
    localparam logic [DATA_W-1:0] TAG_LONG  = DATA_W'(8'h4C);  // "L"
    localparam logic [DATA_W-1:0] TAG_SHORT = DATA_W'(8'h53);  // "S"

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SEP     = 2'd2,
        S_TAG     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SEP     = 2'd2
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              write_q, write_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       timer_q, timer_d;
    logic              drop_q, drop_d;
    logic              drop_set;
    logic [7:0]        cnt_inc;
    logic [15:0]       timer_inc;
`ifdef TOKEN_SAVER_TAG_EN
    logic              tag_long_q, tag_long_d;
`endif

    assign cnt_inc   = cnt_q + 8'd1;
    assign timer_inc = (timer_q >= TIMER_LAST) ? TIMER_LAST : timer_q + 16'd1;

    // Next-state and output decode for the capture sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        data_d   = data_q;
        write_d  = 1'b0;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        drop_set = 1'b0;
`ifdef TOKEN_SAVER_TAG_EN
        tag_long_d = tag_long_q;
`endif
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (long || short) begin
`ifdef TOKEN_SAVER_TAG_EN
                        state_d    = S_TAG;
                        tag_long_d = long;
`else
                        state_d    = S_CAPTURE;
`endif
                        cnt_d   = 8'd0;
                        timer_d = 16'd0;
                    end
                end
`ifdef TOKEN_SAVER_TAG_EN
                S_TAG: begin
                    if (!fifo_full) begin
                        data_d  = tag_long_q ? TAG_LONG : TAG_SHORT;
                        write_d = 1'b1;
                    end else begin
                        drop_set = 1'b1;
                    end
                    state_d = S_CAPTURE;
                end
`endif
                S_CAPTURE: begin
                    if (is_number && !fifo_full) begin
                        data_d  = data_in;
                        write_d = 1'b1;
                        cnt_d   = cnt_inc;
                        timer_d = 16'd0;
                        if (cnt_inc == MAX_CNT) begin
                            state_d = S_SEP;
                        end
                    end else if (is_number) begin
                        drop_set = 1'b1;
                        timer_d  = 16'd0;
                    end else if (TERM_ON_NONDIGIT && cnt_q != 8'd0) begin
                        state_d = S_SEP;
                    end else begin
                        timer_d = timer_inc;
                        if (timer_inc == TIMER_LAST) begin
                            // An empty token is abandoned without a separator.
                            state_d = (cnt_q != 8'd0) ? S_SEP : S_IDLE;
                        end
                    end
                end
                S_SEP: begin
                    if (!fifo_full) begin
                        data_d  = SEP_CHAR;
                        write_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // A new drop wins over a clear in the same cycle; clearing ignores en.
        drop_d = drop_set | (drop_q & ~clr_err);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= 8'd0;
            timer_q <= 16'd0;
            drop_q  <= 1'b0;
`ifdef TOKEN_SAVER_TAG_EN
            tag_long_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
`ifdef TOKEN_SAVER_TAG_EN
            tag_long_q <= tag_long_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign write     = write_q;
    assign busy      = (state_q != S_IDLE);
    assign digit_cnt = cnt_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_token_saver.sv
// Testbench for token_saver. Two instances share one stimulus stream: the
// default configuration, and a variant with TERM_ON_NONDIGIT=0, MAX_DIGITS=3
// and TIMEOUT=16. A token-level reference model predicts the outputs of both
// instances every cycle. Directed sequences pin the written characters to
// literal strings.
module tb_token_saver;

`ifdef TOKEN_SAVER_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    localparam int MAXD [2] = '{8, 3};
    localparam int TMO  [2] = '{255, 16};
    localparam bit TERM [2] = '{1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_s = 1'b0, num_s = 1'b0, long_s = 1'b0, short_s = 1'b0;
    logic       full_s = 1'b0, clr_s = 1'b0;
    logic [7:0] data_s = 8'h00;

    logic [7:0] dout0, dout1, cnt0, cnt1;
    logic       wr0, wr1, busy0, busy1, err0, err1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    token_saver dut0 (
        .clk(clk), .rst_n(rst_n), .en(en_s), .data_in(data_s), .is_number(num_s),
        .long(long_s), .short(short_s), .fifo_full(full_s), .clr_err(clr_s),
        .data_out(dout0), .write(wr0), .busy(busy0), .digit_cnt(cnt0), .drop_err(err0)
    );

    token_saver #(.MAX_DIGITS(3), .TERM_ON_NONDIGIT(1'b0), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en_s), .data_in(data_s), .is_number(num_s),
        .long(long_s), .short(short_s), .fifo_full(full_s), .clr_err(clr_s),
        .data_out(dout1), .write(wr1), .busy(busy1), .digit_cnt(cnt1), .drop_err(err1)
    );

    // ---------------- reference model (token level) ----------------
    bit       m_busy  [2];   // inside a token (trigger seen, separator not yet written)
    bit       m_tag   [2];   // tag character still owed
    bit       m_close [2];   // token finished, separator owed
    bit       m_long  [2];
    int       m_cnt   [2];
    int       m_quiet [2];   // en cycles since last digit
    bit       m_wr    [2];
    bit [7:0] m_dout  [2];
    bit       m_derr  [2];

    function automatic void emit(int k, bit [7:0] v);
        m_wr[k]   = 1'b1;
        m_dout[k] = v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_tag[k] = 0; m_close[k] = 0; m_long[k] = 0;
            m_cnt[k] = 0; m_quiet[k] = 0; m_wr[k] = 0; m_dout[k] = 8'h00; m_derr[k] = 0;
        end
    endfunction

    function automatic void model_step(int k);
        bit set_err = 1'b0;
        m_wr[k] = 1'b0;
        if (en_s) begin
            if (!m_busy[k]) begin
                if (long_s || short_s) begin
                    m_busy[k] = 1; m_cnt[k] = 0; m_quiet[k] = 0;
                    m_tag[k] = TAG_EN; m_close[k] = 0; m_long[k] = long_s;
                end
            end else if (m_tag[k]) begin
                m_tag[k] = 0;
                if (full_s) set_err = 1'b1;
                else emit(k, m_long[k] ? 8'h4C : 8'h53);
            end else if (m_close[k]) begin
                if (!full_s) begin
                    emit(k, 8'h20);
                    m_busy[k] = 0;
                    m_close[k] = 0;
                end
            end else if (num_s) begin
                m_quiet[k] = 0;
                if (full_s) set_err = 1'b1;
                else begin
                    emit(k, data_s);
                    m_cnt[k]++;
                    if (m_cnt[k] == MAXD[k]) m_close[k] = 1;
                end
            end else if (TERM[k] && m_cnt[k] > 0) begin
                m_close[k] = 1;
            end else begin
                m_quiet[k]++;
                if (m_quiet[k] >= TMO[k] - 1) begin
                    if (m_cnt[k] > 0) m_close[k] = 1;
                    else m_busy[k] = 0;
                end
            end
        end
        if (set_err) m_derr[k] = 1'b1;
        else if (clr_s) m_derr[k] = 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(int k, logic [7:0] dout, logic wr, logic busy, logic [7:0] cnt, logic err);
        check($sformatf("dut%0d.write", k), 32'(wr), 32'(m_wr[k]));
        check($sformatf("dut%0d.data_out", k), 32'(dout), 32'(m_dout[k]));
        check($sformatf("dut%0d.busy", k), 32'(busy), 32'(m_busy[k]));
        check($sformatf("dut%0d.digit_cnt", k), 32'(cnt), 32'(m_cnt[k]));
        check($sformatf("dut%0d.drop_err", k), 32'(err), 32'(m_derr[k]));
    endtask

    // Compare both instances with the model every cycle and log DUT writes.
    always @(negedge clk) begin
        cmp(0, dout0, wr0, busy0, cnt0, err0);
        cmp(1, dout1, wr1, busy1, cnt1, err1);
        if (wr0) q0.push_back(dout0);
        if (wr1) q1.push_back(dout1);
    end

    task automatic check_q(string name, int k, string exp);
        int n = (k == 0) ? q0.size() : q1.size();
        check({name, ".len"}, 32'(n), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < n; i++)
            check($sformatf("%s[%0d]", name, i), 32'((k == 0) ? q0[i] : q1[i]), 32'(exp[i]));
    endtask

    // ---------------- stimulus helpers ----------------
    // Drive one cycle of inputs, consume one clock edge, return 2ns after it.
    task automatic cyc(bit e, bit num, logic [7:0] d, bit lg = 0, bit sh = 0, bit full = 0, bit clr = 0);
        en_s = e; num_s = num; data_s = d; long_s = lg; short_s = sh; full_s = full; clr_s = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic trig(bit lg, bit sh);
        cyc(1, 0, 8'h2E, lg, sh);
        if (TAG_EN) cyc(1, 0, 8'h2E);   // tag cycle, data ignored
    endtask

    task automatic settle();
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            cyc(1, 0, 8'h2E);
            if (!busy0 && !busy1) done = 1'b1;
        end
        check("settle_idle", 32'(done), 32'd1);
        cyc(0, 0, 8'h00);
        @(negedge clk);
        #1;
        q0.delete();
        q1.delete();
    endtask

    string pre_s, pre_l;

    initial begin
        if (TAG_EN) begin pre_s = "S"; pre_l = "L"; end
        else begin pre_s = ""; pre_l = ""; end

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        check("reset.data_out", 32'(dout0), 32'd0);
        check("reset.write", 32'(wr0), 32'd0);
        check("reset.busy", 32'(busy0), 32'd0);
        check("reset.digit_cnt", 32'(cnt0), 32'd0);
        check("reset.drop_err", 32'(err0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short trigger, "123x": token closes on the non-digit.
        settle();
        trig(0, 1);
        cyc(1, 1, "1"); cyc(1, 1, "2"); cyc(1, 1, "3"); cyc(1, 0, "x");
        check("t1.busy_in_sep", 32'(busy0), 32'd1);
        cyc(1, 0, 8'h2E);
        check("t1.busy_after_sep", 32'(busy0), 32'd0);
        check("t1.digit_cnt", 32'(cnt0), 32'd3);
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        check_q("t1.q0", 0, {pre_s, "123 "});
        check_q("t1.q1", 1, {pre_s, "123 "});

        // Ten digits with MAX_DIGITS=8: "8" slot writes the separator, "9" ignored.
        settle();
        trig(1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 8'h30 + 8'(i));
        check("t2.busy", 32'(busy0), 32'd0);
        check("t2.digit_cnt", 32'(cnt0), 32'd8);
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        check_q("t2.q0", 0, {pre_l, "01234567 "});

        // Digit lost to fifo_full, sticky drop_err until clr_err.
        settle();
        trig(0, 1);
        cyc(1, 1, "5"); cyc(1, 1, "6", 0, 0, 1); cyc(1, 1, "7"); cyc(1, 0, "q"); cyc(1, 0, 8'h2E);
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        check_q("t3.q0", 0, {pre_s, "57 "});
        check("t3.drop_err_set", 32'(err0), 32'd1);
        repeat (3) cyc(0, 0, 8'h00);
        check("t3.drop_err_held", 32'(err0), 32'd1);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        check("t3.drop_err_clr", 32'(err0), 32'd0);

        // Empty token times out after the 254th en cycle.
        settle();
        trig(0, 1);
        repeat (253) cyc(1, 0, 8'h2E);
        check("t4.busy_253", 32'(busy0), 32'd1);
        cyc(1, 0, 8'h2E);
        check("t4.busy_254", 32'(busy0), 32'd0);
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        check_q("t4.q0", 0, pre_s);

        // TERM_ON_NONDIGIT=0 instance: "4" then non-digits closes by timeout.
        settle();
        trig(0, 1);
        cyc(1, 1, "4");
        repeat (255) cyc(1, 0, 8'h2E);
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        check_q("t4b.q1", 1, {pre_s, "4 "});
        check_q("t4b.q0", 0, {pre_s, "4 "});
        check("t4b.cnt1", 32'(cnt1), 32'd1);

        // Separator held while fifo_full, then written exactly once.
        settle();
        trig(0, 1);
        cyc(1, 1, "1"); cyc(1, 0, "x");
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'h2E, 0, 0, 1);
            check("t5.no_write_full", 32'(wr0), 32'd0);
            check("t5.busy_full", 32'(busy0), 32'd1);
        end
        cyc(1, 0, 8'h2E);
        check("t5.sep_write", 32'(wr0), 32'd1);
        check("t5.sep_char", 32'(dout0), 32'h20);
        cyc(1, 0, 8'h2E);
        check("t5.write_pulse", 32'(wr0), 32'd0);
        @(negedge clk); #1;
        check_q("t5.q0", 0, {pre_s, "1 "});

        // Reset mid-token: outputs clear at once, no separator follows.
        settle();
        trig(1, 0);
        cyc(1, 1, "1"); cyc(1, 1, "2");
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst.data_out", 32'(dout0), 32'd0);
        check("rst.write", 32'(wr0), 32'd0);
        check("rst.busy", 32'(busy0), 32'd0);
        check("rst.digit_cnt", 32'(cnt0), 32'd0);
        cyc(1, 0, "x");
        rst_n = 1'b1;
        repeat (4) cyc(1, 0, "x");
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        check_q("rst.q0", 0, {pre_l, "12"});

        // Both triggers at once: long wins for the tag.
        settle();
        trig(1, 1);
        cyc(1, 1, "9"); cyc(1, 0, "z"); cyc(1, 0, 8'h2E);
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        check_q("t6.q0", 0, {pre_l, "9 "});

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit       e, n;
            logic [7:0] d;
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk); #1;
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            e = ($urandom_range(0, 3) != 0);
            n = 1'($urandom_range(0, 1));
            d = n ? 8'h30 + 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            cyc(e, n, d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
        end
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
